md_sched: RTL and testbench

- Multiply/divide scheduler for the HI/LO resource.
- Accepts an issue strobe from the E stage and runs a fixed-latency multi-cycle operation.
- Owns the architectural HI and LO registers, which it commits on completion.
- Raises a pipeline stall while a D-stage HI/LO instruction would race the unit. The HILO value that M-stage captures comes from its read port.

---
 rtl/md_sched.sv | 80 ++++++++
 tb/tb_md_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning the architectural HI/LO registers.
// Define MD_MADD_EN to enable md_op 7 (madd, accumulate into {HI,LO}).
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    input  logic        rd_sel,
    output logic [31:0] hilo_out,
    output logic        busy,
    output logic        stall
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

    logic [CW-1:0] count;
    logic [31:0]   hi, lo, pend_hi, pend_lo;
    logic          skip, acc, op_ok, start_eff, go, is_div;
    logic [63:0]   s_prod, u_prod, res;
    logic [31:0]   ua, ub, q_mag, r_mag, s_quo, s_rem;

`ifdef MD_MADD_EN
    assign op_ok = md_op != 3'd0;
`else
    assign op_ok = md_op != 3'd0 && md_op != 3'd7;
`endif
    assign start_eff = start && !req && op_ok;
    assign go        = start_eff && !busy;
    assign is_div    = md_op == 3'd3 || md_op == 3'd4;
    assign busy      = count != '0;
    assign stall     = d_md_use && (busy || start_eff);
    assign hilo_out  = rd_sel ? hi : lo;

    assign s_prod = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign u_prod = {32'd0, rs_val} * {32'd0, rt_val};
    // Signed divide through magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
    assign ua    = rs_val[31] ? -rs_val : rs_val;
    assign ub    = rt_val[31] ? -rt_val : rt_val;
    assign q_mag = (ub == '0) ? '0 : ua / ub;
    assign r_mag = (ub == '0) ? '0 : ua % ub;
    assign s_quo = (rs_val[31] ^ rt_val[31]) ? -q_mag : q_mag;
    assign s_rem = rs_val[31] ? -r_mag : r_mag;
    assign res   = (md_op == 3'd2) ? u_prod :
                   (md_op == 3'd3) ? {s_rem, s_quo} :
                   (md_op == 3'd4) ? {((rt_val == '0) ? '0 : rs_val % rt_val), ((rt_val == '0) ? '0 : rs_val / rt_val)} :
                   s_prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            skip    <= 1'b0;
            acc     <= 1'b0;
        end else if (go) begin
            if (md_op == 3'd5) hi <= rs_val;
            else if (md_op == 3'd6) lo <= rs_val;
            else begin
                count              <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                {pend_hi, pend_lo} <= res;
                skip               <= is_div && rt_val == '0;
                acc                <= md_op == 3'd7;
            end
        end else if (busy) begin
            count <= count - CW'(1);
            // madd sums against HI/LO as they stand at commit, not at issue.
            if (count == CW'(1) && !skip)
                {hi, lo} <= acc ? {hi, lo} + {pend_hi, pend_lo} : {pend_hi, pend_lo};
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: randomized self-checking bench for md_sched against a 64-bit arithmetic model.
module tb_md_sched;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 0, reset = 0, req = 0, start = 0, d_md_use = 0, rd_sel = 0;
    logic [2:0]  md_op = 0;
    logic [31:0] rs_val = 0, rt_val = 0;
    logic [31:0] hilo_out;
    logic        busy, stall;
    int          checks = 0, failures = 0;
    logic [31:0] exp_hi = 0, exp_lo = 0;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .d_md_use(d_md_use), .rd_sel(rd_sel),
        .hilo_out(hilo_out), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return ua * ub;
            3'd3: return (b == 0) ? {hi, lo} : {32'(sa % sb), 32'(sa / sb)};
            3'd4: return (b == 0) ? {hi, lo} : {32'(ua % ub), 32'(ua / ub)};
            3'd5: return {a, lo};
            3'd6: return {hi, a};
`ifdef MD_MADD_EN
            3'd7: return {hi, lo} + 64'(sa * sb);
`endif
            default: return {hi, lo};
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op);
`ifdef MD_MADD_EN
        if (op == 3'd7) return MC;
`endif
        return (op == 3'd1 || op == 3'd2) ? MC : (op == 3'd3 || op == 3'd4) ? DC : 0;
    endfunction

    task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
        rd_sel = 1; #1 h = hilo_out;
        rd_sel = 0; #1 l = hilo_out;
    endtask

    // Issues one op (d_md_use low in the start cycle), then counts busy and stall cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, input logic use_d, rq,
                          output int nb, output int ns);
        @(negedge clk);
        md_op = op; rs_val = a; rt_val = b; start = 1; req = rq; d_md_use = 0;
        @(negedge clk);
        start = 0; md_op = 0; req = 0; d_md_use = use_d; nb = 0; ns = 0;
        #1;
        while (busy && nb < 40) begin
            nb++;
            if (stall) ns++;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] h, l;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        read_hl(h, l);
        checks++; if ({h, l} !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0", h, l); end
        reset = 1;
    endtask

    task automatic test_mult;
        int nb, ns; logic [31:0] h, l;
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, nb, ns);
        checks++; if (nb !== MC) begin failures++; $display("FAIL mult_busy got=%0d exp=%0d", nb, MC); end
        checks++; if (ns !== 0) begin failures++; $display("FAIL mult_stall got=%0d exp=0", ns); end
        {exp_hi, exp_lo} = 64'hFFFF_FFFF_FFFF_FFFE;
        read_hl(h, l);
        checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL mult_hilo got=%h_%h exp=%h_%h", h, l, exp_hi, exp_lo); end
    endtask

    task automatic test_divu_stall;
        int nb, ns; logic [31:0] h, l;
        run_op(3'd4, 32'd7, 32'd2, 1, 0, nb, ns);
        checks++; if (nb !== DC) begin failures++; $display("FAIL divu_busy got=%0d exp=%0d", nb, DC); end
        checks++; if (ns !== DC) begin failures++; $display("FAIL divu_stall got=%0d exp=%0d", ns, DC); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL divu_stall_end got=%b exp=0", stall); end
        exp_hi = 1; exp_lo = 3;
        read_hl(h, l);
        checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL divu_hilo got=%h_%h exp=%h_%h", h, l, exp_hi, exp_lo); end
        d_md_use = 0;
    endtask

    task automatic test_div_edge;
        int nb, ns; logic [31:0] h, l;
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, nb, ns);
        exp_hi = 0; exp_lo = 32'h8000_0000;
        read_hl(h, l);
        checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL div_ovf got=%h_%h exp=%h_%h", h, l, exp_hi, exp_lo); end
        run_op(3'd5, 32'h0000_ABCD, 0, 0, 0, nb, ns);
        exp_hi = 32'h0000_ABCD;
        run_op(3'd3, 32'd5, 32'd0, 0, 0, nb, ns);
        checks++; if (nb !== DC) begin failures++; $display("FAIL div0_busy got=%0d exp=%0d", nb, DC); end
        read_hl(h, l);
        checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL div0_hilo got=%h_%h exp=%h_%h", h, l, exp_hi, exp_lo); end
    endtask

    task automatic test_req;
        int nb, ns; logic [31:0] h, l;
        run_op(3'd1, 32'd3, 32'd3, 0, 1, nb, ns);
        checks++; if (nb !== 0) begin failures++; $display("FAIL req_cancel_busy got=%0d exp=0", nb); end
        read_hl(h, l);
        checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL req_cancel_hilo got=%h_%h exp=%h_%h", h, l, exp_hi, exp_lo); end
        @(negedge clk);
        md_op = 3'd1; rs_val = 3; rt_val = 3; start = 1;
        @(negedge clk);
        start = 0; md_op = 0; nb = 0;
        #1;
        while (busy && nb < 40) begin
            nb++;
            req = (nb == 2);
            @(negedge clk); #1;
        end
        req = 0;
        checks++; if (nb !== MC) begin failures++; $display("FAIL req_mid_busy got=%0d exp=%0d", nb, MC); end
        exp_hi = 0; exp_lo = 9;
        read_hl(h, l);
        checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL req_mid_hilo got=%h_%h exp=%h_%h", h, l, exp_hi, exp_lo); end
    endtask

    task automatic test_mt;
        int nb, ns; logic [31:0] h, l;
        run_op(3'd6, 32'h0000_1234, 0, 0, 0, nb, ns);
        exp_lo = 32'h0000_1234;
        checks++; if (nb !== 0) begin failures++; $display("FAIL mtlo_busy got=%0d exp=0", nb); end
        read_hl(h, l);
        checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL mtlo_hilo got=%h_%h exp=%h_%h", h, l, exp_hi, exp_lo); end
        @(negedge clk);
        md_op = 3'd5; rs_val = 32'h5A5A_0001; start = 1; d_md_use = 1;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mthi_stall_start got=%b exp=1", stall); end
        @(negedge clk);
        start = 0; md_op = 0;
        #1;
        checks++; if (stall !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mthi_after got=stall%b_busy%b exp=0_0", stall, busy); end
        exp_hi = 32'h5A5A_0001;
        read_hl(h, l);
        checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL mthi_hilo got=%h_%h exp=%h_%h", h, l, exp_hi, exp_lo); end
        d_md_use = 0;
    endtask

    task automatic test_back_to_back;
        int nb; logic [31:0] h, l;
        @(negedge clk);
        md_op = 3'd2; rs_val = 32'h0001_0000; rt_val = 32'h0003_0000; start = 1;
        @(negedge clk);
        start = 0; md_op = 0; nb = 0;
        #1;
        while (busy && nb < 40) begin
            nb++;
            start = (nb == 2 || nb == 3);
            md_op = (nb == 2) ? 3'd5 : (nb == 3) ? 3'd1 : 3'd0;
            rs_val = 32'hDEAD_BEEF;
            @(negedge clk); #1;
        end
        start = 0; md_op = 0;
        checks++; if (nb !== MC) begin failures++; $display("FAIL b2b_busy got=%0d exp=%0d", nb, MC); end
        {exp_hi, exp_lo} = 64'h0000_0003_0000_0000;
        read_hl(h, l);
        checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL b2b_hilo got=%h_%h exp=%h_%h", h, l, exp_hi, exp_lo); end
    endtask

    task automatic test_madd;
        int nb, ns; logic [31:0] h, l;
        run_op(3'd5, 0, 0, 0, 0, nb, ns);
        run_op(3'd6, 32'hFFFF_FFFF, 0, 0, 0, nb, ns);
        exp_hi = 0; exp_lo = 32'hFFFF_FFFF;
        @(negedge clk);
        md_op = 3'd7; rs_val = 1; rt_val = 1; start = 1; d_md_use = 1;
        #1;
`ifdef MD_MADD_EN
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL madd_stall got=%b exp=1", stall); end
`else
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL op7_stall got=%b exp=0", stall); end
`endif
        @(negedge clk);
        start = 0; md_op = 0; d_md_use = 0; nb = 0;
        #1;
        while (busy && nb < 40) begin nb++; @(negedge clk); #1; end
`ifdef MD_MADD_EN
        checks++; if (nb !== MC) begin failures++; $display("FAIL madd_busy got=%0d exp=%0d", nb, MC); end
        exp_hi = 1; exp_lo = 0;
`else
        checks++; if (nb !== 0) begin failures++; $display("FAIL op7_busy got=%0d exp=0", nb); end
`endif
        read_hl(h, l);
        checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL op7_hilo got=%h_%h exp=%h_%h", h, l, exp_hi, exp_lo); end
    endtask

    task automatic test_random;
        int nb, ns, lat; logic [31:0] h, l, a, b; logic [2:0] op; logic use_d, rq;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 7));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            use_d = 1'($urandom_range(0, 1));
            rq = ($urandom_range(0, 6) == 0);
            lat = rq ? 0 : latency(op);
            if (!rq) {exp_hi, exp_lo} = model(op, a, b, exp_hi, exp_lo);
            run_op(op, a, b, use_d, rq, nb, ns);
            checks++; if (nb !== lat) begin failures++; $display("FAIL rnd%0d_busy op=%0d got=%0d exp=%0d", i, op, nb, lat); end
            checks++; if (ns !== (use_d ? lat : 0)) begin failures++; $display("FAIL rnd%0d_stall op=%0d got=%0d exp=%0d", i, op, ns, use_d ? lat : 0); end
            read_hl(h, l);
            checks++; if ({h, l} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, h, l, exp_hi, exp_lo); end
        end
        d_md_use = 0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] h, l;
        @(negedge clk);
        md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7; start = 1;
        @(negedge clk);
        start = 0; md_op = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        exp_hi = 0; exp_lo = 0;
        read_hl(h, l);
        checks++; if ({h, l} !== 64'd0) begin failures++; $display("FAIL rstmid_hilo got=%h_%h exp=0", h, l); end
        @(negedge clk);
        reset = 1;
        repeat (DC + 2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_late got=%b exp=0", busy); end
        read_hl(h, l);
        checks++; if ({h, l} !== 64'd0) begin failures++; $display("FAIL rstmid_hilo_late got=%h_%h exp=0", h, l); end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_divu_stall;
        test_div_edge;
        test_req;
        test_mt;
        test_back_to_back;
        test_madd;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
